// File: rtl/restador_pkg.sv
// restador_pkg: shared state encoding and sizing helpers for the serial subtractor
package restador_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/restador_completo.sv
// restador_completo: combinational full subtractor built from two half-subtractor stages
module restador_completo (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    assign w_d1 = a ^ b;
    assign w_b1 = ~a & b;
    assign d    = w_d1 ^ bin;
    assign w_b2 = ~w_d1 & bin;
    assign bout = w_b1 | w_b2;

endmodule

// File: rtl/restador_serial.sv
// restador_serial: bit-serial A - B, LSB first, one bit per clock with a borrow flip-flop
module restador_serial
    import restador_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Resta,
    output logic             Bout
);

    localparam int CW = cnt_w(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic             w_accept;

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);

    restador_completo u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state: accept from IDLE/DONE, leave SHIFT after the last bit
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start ? S_SHIFT : S_IDLE;
            S_SHIFT: w_next = w_last ? S_DONE : S_SHIFT;
            S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // status outputs decoded from the state
    always_comb begin
        busy = (r_state == S_SHIFT);
        done = (r_state == S_DONE);
    end

    // datapath: load operands, shift one bit per cycle, publish result on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_cnt <= '0;
            r_br  <= 1'b0;
            Resta <= '0;
            Bout  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_br  <= w_bout;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                Resta <= {w_d, r_res[WIDTH-1:1]};
                Bout  <= w_bout;
            end
        end
    end

endmodule
